multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath. It sequences PC, instruction register, memory, register file and ALU across fetch, decode, execute, memory and writeback cycles.
- It drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode by funct.
- It stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and of state_dbg port

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction[31:26] from instruction register
- mem_ready  input  1  memory has completed current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  regfile write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  regfile write address: 0 = rt, 1 = rd
- RegWrite  output  1  regfile write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
- ALUOp  output  2  to ALU control decoder
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state_dbg  output  STATE_W  current state, for bench visibility

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: on any edge with reset=1, state goes to FETCH, including mid-instruction; any pending memory request is abandoned.
- Outputs while reset=1: all outputs combinationally forced to 0.
- Outputs: pure functions of state and mem_ready. Any output not listed for a state is 0.
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Encodings 12-15 go to FETCH.
- FETCH:
  - outputs: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=mem_ready, PCWrite=mem_ready.
  - stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
- DECODE:
  - outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - next state by opcode:
    - 000000 -> EXECUTE
    - 100011 / 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - other -> FETCH, with illegal_op=1 for this cycle only.
- MEM_ADDR:
  - outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - next: lw -> MEM_READ, sw -> MEM_WRITE. Opcode is stable from the IR.
- MEM_READ:
  - outputs: MemRead=1, IorD=1.
  - holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: outputs RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
- MEM_WRITE:
  - outputs: MemWrite=1, IorD=1.
  - holds until mem_ready=1, then goes to FETCH.
- EXECUTE: outputs ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALU_WB.
- ALU_WB: outputs RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
- BRANCH: outputs ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
- JUMP: outputs PCWrite=1, PCSource=10; next FETCH.
- ADDI_EXEC: outputs ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDI_WB.
- ADDI_WB: outputs RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
- Latency with mem_ready held at 1 (cycles, FETCH to next FETCH): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- MemRead and MemWrite are never both 1 in the same cycle.

Decomposition:
- Shared package contents:
  - state encoding constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - ALUSrcB and PCSource select constants.
- No sub-module is needed: a single module holds the state register, the next-state logic and the output decode.

Test Plan:
- Reset while in MEM_READ with mem_ready=0 -> next cycle state_dbg=0, all outputs 0 while reset=1, then MemRead=1 and ALUSrcB=01 after reset deasserts.
- R-type (opcode 000000), mem_ready=1 -> state sequence 0,1,6,7,0; ALUOp=10 only in state 6; RegWrite=1 and RegDst=1 only in state 7.
- lw (100011), mem_ready low for 3 cycles in MEM_READ -> state stays 3 for 4 cycles with IorD=1; then MEM_WB with RegWrite=1, MemtoReg=1; 8 cycles total.
- beq (000100) -> sequence 0,1,8,0; in state 8 ALUOp=01, PCWriteCond=1, PCSource=01, PCWrite=0.
- Opcode 111111 -> illegal_op=1 for exactly one cycle, in DECODE; returns to FETCH; no write enables asserted.
- FETCH with mem_ready=0 for 2 cycles -> IRWrite=0 and PCWrite=0 while stalled, both 1 in the cycle mem_ready=1, then DECODE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multicycle MIPS main control FSM:
//               state encodings, opcodes, ALUOp codes, ALU B-operand and
//               PC-source select codes, and the packed control-word type.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // Main control states (4-bit encoding; 12-15 are unused)
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // Instruction opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp codes seen by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of control outputs, gathered so reset can clear them at once
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_if
// Description : Bundle between the main control FSM and the datapath.
//               master = controller (drives control lines, state_dbg)
//               slave  = datapath   (drives opcode, mem_ready)
// Ports       : opcode[5:0], mem_ready, PC/memory/regfile/ALU controls,
//               illegal_op, state_dbg[STATE_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore-style main control FSM for the multicycle MIPS
//               datapath. Sequences fetch/decode/execute/memory/writeback
//               and stalls on mem_ready in FETCH, MEM_READ and MEM_WRITE.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high
//               bus        - multicycle_control_if.master (opcode, mem_ready
//                            in; all control lines and state_dbg out)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    multicycle_control_if.master   bus
);

    state_t     r_state;
    state_t     w_next;
    ctl_t       w_ctl;
    ctl_t       w_out;
    logic [3:0] w_state_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        w_ctl  = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_ctl.alu_op    = ALUOP_ADD;
                w_ctl.pc_source = PCSRC_ALU;
                // IR and PC only load once the instruction word is valid
                w_ctl.ir_write  = bus.mem_ready;
                w_ctl.pc_write  = bus.mem_ready;
                w_next          = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut <= PC+4 + (imm<<2): branch target ready for BRANCH
                w_ctl.alu_src_b = SRCB_IMM_SH;
                w_ctl.alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default: begin
                        w_ctl.illegal_op = 1'b1;
                        w_next           = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = ALUOP_ADD;
                // Only lw/sw reach here; the IR holds the opcode steady
                w_next          = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                w_ctl.mem_read = 1'b1;
                w_ctl.iord     = 1'b1;
                w_next         = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_ctl.mem_write = 1'b1;
                w_ctl.iord      = 1'b1;
                w_next          = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_B;
                w_ctl.alu_op    = ALUOP_FUNCT;
                w_next          = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_dst   = 1'b1;
                w_next          = S_FETCH;
            end
            S_BRANCH: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_src_b     = SRCB_B;
                w_ctl.alu_op        = ALUOP_SUB;
                w_ctl.pc_write_cond = 1'b1;
                w_ctl.pc_source     = PCSRC_ALUOUT;
                w_next              = S_FETCH;
            end
            S_JUMP: begin
                w_ctl.pc_write  = 1'b1;
                w_ctl.pc_source = PCSRC_JUMP;
                w_next          = S_FETCH;
            end
            S_ADDI_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = ALUOP_ADD;
                w_next          = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_ctl.reg_write = 1'b1;
                w_next          = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset blanks every output combinationally, including state_dbg
    always_comb begin
        w_out        = reset ? '0 : w_ctl;
        w_state_bits = reset ? 4'd0 : r_state;
    end

    assign bus.PCWrite     = w_out.pc_write;
    assign bus.PCWriteCond = w_out.pc_write_cond;
    assign bus.IorD        = w_out.iord;
    assign bus.MemRead     = w_out.mem_read;
    assign bus.MemWrite    = w_out.mem_write;
    assign bus.IRWrite     = w_out.ir_write;
    assign bus.MemtoReg    = w_out.mem_to_reg;
    assign bus.RegDst      = w_out.reg_dst;
    assign bus.RegWrite    = w_out.reg_write;
    assign bus.ALUSrcA     = w_out.alu_src_a;
    assign bus.ALUSrcB     = w_out.alu_src_b;
    assign bus.ALUOp       = w_out.alu_op;
    assign bus.PCSource    = w_out.pc_source;
    assign bus.illegal_op  = w_out.illegal_op;
    assign bus.state_dbg   = STATE_W'(w_state_bits);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed, table-driven bench for multicycle_control. Each
//               row gives the inputs for one cycle and the expected state
//               and control word seen before the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    // Control word layout (MSB..LSB):
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FGO    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MREAD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MWRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_AEXEC  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    localparam logic [5:0] C_RT  = 6'b000000;
    localparam logic [5:0] C_LW  = 6'b100011;
    localparam logic [5:0] C_SW  = 6'b101011;
    localparam logic [5:0] C_BEQ = 6'b000100;
    localparam logic [5:0] C_J   = 6'b000010;
    localparam logic [5:0] C_ADI = 6'b001000;
    localparam logic [5:0] C_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    function automatic logic [16:0] actual_ctl();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.illegal_op};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [16:0] ctl,
                       input string name);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] act,
                         input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected FETCH-to-FETCH latency with mem_ready held high
    logic [5:0] lat_op  [7];
    int         lat_exp [7];

    initial begin
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;

        // Reset, then R-type with mem_ready=1: 0,1,6,7,0
        add(1, C_RT, 1, 4'd0,  C_ZERO,   "reset_outputs");
        add(0, C_RT, 1, 4'd0,  C_FGO,    "rt_fetch");
        add(0, C_RT, 1, 4'd1,  C_DEC,    "rt_decode");
        add(0, C_RT, 1, 4'd6,  C_EXEC,   "rt_execute");
        add(0, C_RT, 1, 4'd7,  C_ALUWB,  "rt_aluwb");
        // lw with three stall cycles in MEM_READ: 8 cycles total
        add(0, C_LW, 1, 4'd0,  C_FGO,    "lw_fetch");
        add(0, C_LW, 0, 4'd1,  C_DEC,    "lw_decode_mr_ignored");
        add(0, C_LW, 1, 4'd2,  C_MADDR,  "lw_memaddr");
        add(0, C_LW, 0, 4'd3,  C_MREAD,  "lw_read_stall1");
        add(0, C_LW, 0, 4'd3,  C_MREAD,  "lw_read_stall2");
        add(0, C_LW, 0, 4'd3,  C_MREAD,  "lw_read_stall3");
        add(0, C_LW, 1, 4'd3,  C_MREAD,  "lw_read_done");
        add(0, C_LW, 0, 4'd4,  C_MWB,    "lw_memwb");
        // sw with one write stall
        add(0, C_SW, 1, 4'd0,  C_FGO,    "sw_fetch");
        add(0, C_SW, 1, 4'd1,  C_DEC,    "sw_decode");
        add(0, C_SW, 1, 4'd2,  C_MADDR,  "sw_memaddr");
        add(0, C_SW, 0, 4'd5,  C_MWRITE, "sw_write_stall");
        add(0, C_SW, 1, 4'd5,  C_MWRITE, "sw_write_done");
        // beq: 0,1,8,0
        add(0, C_BEQ, 1, 4'd0, C_FGO,    "beq_fetch");
        add(0, C_BEQ, 1, 4'd1, C_DEC,    "beq_decode");
        add(0, C_BEQ, 1, 4'd8, C_BRANCH, "beq_branch");
        // j
        add(0, C_J, 1, 4'd0,   C_FGO,    "j_fetch");
        add(0, C_J, 1, 4'd1,   C_DEC,    "j_decode");
        add(0, C_J, 1, 4'd9,   C_JUMP,   "j_jump");
        // addi
        add(0, C_ADI, 1, 4'd0, C_FGO,    "addi_fetch");
        add(0, C_ADI, 1, 4'd1, C_DEC,    "addi_decode");
        add(0, C_ADI, 1, 4'd10, C_AEXEC, "addi_exec");
        add(0, C_ADI, 1, 4'd11, C_AWB,   "addi_wb");
        // illegal opcode: single-cycle pulse in DECODE, back to FETCH
        add(0, C_BAD, 1, 4'd0, C_FGO,    "ill_fetch");
        add(0, C_BAD, 1, 4'd1, C_DECILL, "ill_decode");
        // FETCH stalled for two cycles
        add(0, C_RT, 0, 4'd0,  C_FSTALL, "fetch_stall1");
        add(0, C_RT, 0, 4'd0,  C_FSTALL, "fetch_stall2");
        add(0, C_RT, 1, 4'd0,  C_FGO,    "fetch_go");
        add(0, C_RT, 1, 4'd1,  C_DEC,    "fetch_then_decode");
        add(0, C_RT, 1, 4'd6,  C_EXEC,   "rt2_execute");
        add(0, C_RT, 1, 4'd7,  C_ALUWB,  "rt2_aluwb");
        // Reset while MEM_READ is stalled
        add(0, C_LW, 1, 4'd0,  C_FGO,    "rlw_fetch");
        add(0, C_LW, 1, 4'd1,  C_DEC,    "rlw_decode");
        add(0, C_LW, 0, 4'd2,  C_MADDR,  "rlw_memaddr");
        add(0, C_LW, 0, 4'd3,  C_MREAD,  "rlw_read_stall");
        add(1, C_LW, 0, 4'd0,  C_ZERO,   "rlw_reset_held1");
        add(1, C_LW, 0, 4'd0,  C_ZERO,   "rlw_reset_held2");
        add(0, C_LW, 0, 4'd0,  C_FSTALL, "rlw_after_reset");

        @(negedge clk);
        foreach (vecs[i]) begin
            reset         = vecs[i].rst;
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].mr;
            #1;
            check({vecs[i].name, "_state"}, {13'd0, bus.state_dbg},
                  {13'd0, vecs[i].st});
            check({vecs[i].name, "_ctl"}, actual_ctl(), vecs[i].ctl);
            // Read and write requests must never overlap
            check({vecs[i].name, "_rw_excl"},
                  {16'd0, bus.MemRead & bus.MemWrite}, 17'd0);
            @(negedge clk);
        end

        // Hand-written latency sequences, mem_ready held high
        lat_op[0] = C_RT;  lat_exp[0] = 4;
        lat_op[1] = C_LW;  lat_exp[1] = 5;
        lat_op[2] = C_SW;  lat_exp[2] = 4;
        lat_op[3] = C_BEQ; lat_exp[3] = 3;
        lat_op[4] = C_J;   lat_exp[4] = 3;
        lat_op[5] = C_ADI; lat_exp[5] = 4;
        lat_op[6] = C_BAD; lat_exp[6] = 2;
        for (int k = 0; k < 7; k++) begin
            int cyc;
            reset         = 1'b1;
            bus.opcode    = lat_op[k];
            bus.mem_ready = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            cyc   = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (bus.state_dbg != 4'd0 && cyc < 20);
            check($sformatf("latency_op%06b", lat_op[k]), 17'(cyc),
                  17'(lat_exp[k]));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
